// File: rtl/cla_word_sequencer_if.sv
// Request/result bundle between a requester and cla_word_sequencer.
//   start/sub/cin/a/b : request fields, driven by the requester (master)
//   busy/done/s/cout/ovf : status and result, driven by the sequencer (slave)
interface cla_word_sequencer_if #(
    parameter int unsigned NBIT   = 4,
    parameter int unsigned NWORDS = 4
);
    localparam int unsigned W = NBIT * NWORDS;

    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;

    modport master (
        output start, sub, cin, a, b,
        input  busy, done, s, cout, ovf
    );

    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, s, cout, ovf
    );
endinterface

// File: rtl/cla_word_sequencer.sv
// Multi-word add/subtract sequencer driving one narrow carry-lookahead adder.
// Operands of NBIT*NWORDS bits are processed one NBIT word per cycle, LSW
// first, with the inter-word carry kept in a register.
//   clk, rst_n : clock, async active-low reset
//   bus        : request/result bundle (slave side), see cla_word_sequencer_if

// Combinational NBIT-wide carry-lookahead adder.
//   a, b, cin : operands and carry in
//   sum_c     : sum word
//   cout_c    : carry out of the top bit
module cla_adder #(
    parameter int unsigned NBIT = 4
) (
    input  logic [NBIT-1:0] a,
    input  logic [NBIT-1:0] b,
    input  logic            cin,
    output logic [NBIT-1:0] sum_c,
    output logic            cout_c
);
    logic [NBIT-1:0] gen_c;
    logic [NBIT-1:0] prop_c;
    logic [NBIT:0]   carry_c;
    logic            term_c;

    assign gen_c  = a & b;
    assign prop_c = a ^ b;

    // Each carry is a flat sum-of-products of generate/propagate terms and cin,
    // so no carry depends on a lower carry.
    always_comb begin
        carry_c    = '0;
        term_c     = 1'b0;
        carry_c[0] = cin;
        for (int i = 0; i < int'(NBIT); i++) begin
            term_c = cin;
            for (int j = 0; j <= i; j++) begin
                term_c = term_c & prop_c[j];
            end
            carry_c[i+1] = term_c;
            for (int k = 0; k <= i; k++) begin
                term_c = gen_c[k];
                for (int j = k + 1; j <= i; j++) begin
                    term_c = term_c & prop_c[j];
                end
                carry_c[i+1] = carry_c[i+1] | term_c;
            end
        end
    end

    assign sum_c  = prop_c ^ carry_c[NBIT-1:0];
    assign cout_c = carry_c[NBIT];
endmodule

module cla_word_sequencer #(
    parameter int unsigned NBIT   = 4,
    parameter int unsigned NWORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cla_word_sequencer_if.slave  bus
);
    localparam int unsigned W    = NBIT * NWORDS;
    localparam int unsigned IDXW = $clog2(NWORDS);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              sub_q, sub_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      s_q, s_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [NBIT-1:0]   op_a_c;
    logic [NBIT-1:0]   op_b_c;
    logic [NBIT-1:0]   sum_c;
    logic              add_cout_c;
    logic              last_c;

    // Current word selection; B is inverted in subtract mode (A + ~B + 1).
    assign last_c = (idx_q == IDXW'(NWORDS - 1));
    assign op_a_c = a_q[idx_q*NBIT +: NBIT];
    assign op_b_c = sub_q ? ~b_q[idx_q*NBIT +: NBIT] : b_q[idx_q*NBIT +: NBIT];

    cla_adder #(
        .NBIT (NBIT)
    ) u_cla (
        .a      (op_a_c),
        .b      (op_b_c),
        .cin    (carry_q),
        .sum_c  (sum_c),
        .cout_c (add_cout_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start) state_d = RUN;
            RUN:  if (last_c)    state_d = IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        idx_d   = idx_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sub_d   = bus.sub;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                s_d[idx_q*NBIT +: NBIT] = sum_c;
                carry_d = add_cout_c;
                idx_d   = idx_q + 1'b1;
                if (last_c) begin
                    idx_d  = '0;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    cout_d = add_cout_c;
                    // Operands share a sign but the result sign differs.
                    ovf_d  = (a_q[W-1] == op_b_c[NBIT-1]) &&
                             (sum_c[NBIT-1] != a_q[W-1]);
                end
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.s    = s_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_cla_word_sequencer.sv
// Self-checking bench for cla_word_sequencer: directed scenarios plus
// randomized operations compared against a plain-arithmetic reference.
module tb_cla_word_sequencer;
    localparam int unsigned NBIT   = 4;
    localparam int unsigned NWORDS = 4;
    localparam int unsigned W      = NBIT * NWORDS;

    logic clk;
    logic rst_n;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_s;
    logic         exp_cout;
    logic         exp_ovf;

    cla_word_sequencer_if #(.NBIT(NBIT), .NWORDS(NWORDS)) bus ();

    cla_word_sequencer #(
        .NBIT   (NBIT),
        .NWORDS (NWORDS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: full-width unsigned/signed integer arithmetic.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sub, input logic cin,
                                  output logic [W-1:0] s, output logic co,
                                  output logic ov);
        longint lim, ua, ub, sa, sb, r, sr;
        lim = longint'(64'(1) << W);
        ua  = longint'(a);
        ub  = longint'(b);
        sa  = a[W-1] ? ua - lim : ua;
        sb  = b[W-1] ? ub - lim : ub;
        if (sub) begin
            r  = ua - ub;
            if (r < 0) r = r + lim;
            co = (ua >= ub);
            sr = sa - sb;
        end else begin
            r  = ua + ub + longint'(cin);
            co = (r >= lim);
            if (r >= lim) r = r - lim;
            sr = sa + sb + longint'(cin);
        end
        s  = r[W-1:0];
        ov = (sr > lim / 2 - 1) || (sr < -(lim / 2));
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_s"},    bus.s,    0);
        check({tag, "_cout"}, bus.cout, 0);
        check({tag, "_ovf"},  bus.ovf,  0);
    endtask

    // Called at a negedge while idle or in the done cycle; returns at the
    // negedge following the accepting edge, with inputs scrambled.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic cin);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.sub   = sub;
        bus.cin   = cin;
        model(a, b, sub, cin, exp_s, exp_cout, exp_ovf);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.sub   = 1'($urandom);
        bus.cin   = 1'($urandom);
        check("busy_after_start", bus.busy, 1);
        check("done_after_start", bus.done, 0);
    endtask

    task automatic wait_done(input int exp_lat);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 3 * int'(NWORDS)) begin
            check("busy_in_run", bus.busy, 1);
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("latency", n, exp_lat);
        check("s",       bus.s,    exp_s);
        check("cout",    bus.cout, exp_cout);
        check("ovf",     bus.ovf,  exp_ovf);
        check("busy_at_done", bus.busy, 0);
    endtask

    task automatic after_done();
        @(posedge clk);
        @(negedge clk);
        check("done_pulse_end", bus.done, 0);
        check("busy_idle",      bus.busy, 0);
        check("s_held",         bus.s,    exp_s);
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b1, {(W-1){1'b0}}};
            3:       v = {1'b0, {(W-1){1'b1}}};
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        logic seen_done;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle_after_reset");

        // Scenario 1: carry ripples across every word.
        launch(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        check("s1_model_s", exp_s, 16'h0000);
        wait_done(NWORDS);
        after_done();

        // Scenario 2: cin, then signed overflow.
        launch(16'h1234, 16'h1111, 1'b0, 1'b1);
        wait_done(NWORDS);
        after_done();
        launch(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_done(NWORDS);
        check("s2_ovf_const", bus.ovf, 1);
        after_done();

        // Scenario 3: subtraction with borrow, then overflow.
        launch(16'h0005, 16'h0007, 1'b1, 1'b1);
        wait_done(NWORDS);
        check("s3_sub_s", bus.s, 16'hFFFE);
        after_done();
        launch(16'h8000, 16'h0001, 1'b1, 1'b0);
        wait_done(NWORDS);
        check("s3_sub_ovf_s", bus.s, 16'h7FFF);
        after_done();

        // Scenario 4: start while busy is ignored; start in done cycle accepted.
        launch(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'hAAAA;
        bus.b     = 16'h5555;
        bus.sub   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(NWORDS - 2);
        check("s4_ignored_s", bus.s, 16'h1000);
        launch(16'h0001, 16'h0001, 1'b0, 1'b0);
        wait_done(NWORDS);
        check("s4_b2b_s", bus.s, 16'h0002);
        after_done();

        // Scenario 5: asynchronous reset mid-run.
        launch(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (2 * NWORDS) begin
            @(posedge clk);
            @(negedge clk);
            seen_done = seen_done | bus.done;
        end
        check("no_done_after_abort", seen_done, 0);
        check("idle_after_abort", bus.busy, 0);
        launch(16'h0003, 16'h0004, 1'b0, 1'b0);
        wait_done(NWORDS);
        check("s5_fresh_s", bus.s, 16'h0007);
        after_done();

        // Randomized operations, sometimes back-to-back.
        for (int i = 0; i < 40; i++) begin
            launch(pick_operand(), pick_operand(), 1'($urandom), 1'($urandom));
            wait_done(NWORDS);
            if ($urandom_range(0, 1) == 0) after_done();
        end
        after_done();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
